ife_deser_bitslip: RTL and testbench

- Input-side counterpart to the edge-clocked output register.
- Captures a serial data pin on ECLK through an input register with clock enable.
- Assembles WIDTH-bit words and presents each with a one-cycle valid strobe.
- Supports a bit-slip request/acknowledge handshake so downstream logic can shift word alignment by one bit.
- Sits directly behind the pad in the I/O ring and feeds fabric logic in the ECLK domain.

---
 rtl/ife_deser_bitslip_if.sv | 22 ++
 rtl/ife_deser_bitslip.sv | 110 +++++++++++
 tb/tb_ife_deser_bitslip.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ife_deser_bitslip_if.sv
// Serial-in / parallel-out bundle for the edge-clocked input deserializer.
// Master drives the pad side; slave is the deserializer.
interface ife_deser_bitslip_if #(
   parameter int WIDTH = 4
);
   logic             d;
   logic             sp;
   logic             bslip;
   logic [WIDTH-1:0] q;
   logic             qvalid;
   logic             slip_ack;

   modport master (
      output d, sp, bslip,
      input  q, qvalid, slip_ack
   );

   modport slave (
      input  d, sp, bslip,
      output q, qvalid, slip_ack
   );
endinterface

// File: rtl/ife_deser_bitslip.sv
// Edge-clocked input deserializer with bit-slip alignment.
// Pad bit -> input register -> shift assembly -> word + valid strobe.
module ife_deser_bitslip #(
   parameter int               WIDTH     = 4,
   parameter bit               MSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] INIT      = '0
) (
   input logic               eclk,
   input logic               rst,
   ife_deser_bitslip_if.slave io
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SLIP  = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic             din_r;
   logic             acc_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_nx;
   logic [WIDTH-1:0] q_r;
   logic             qvalid_r;
   logic             ack_r;
   logic             take;
   logic             drop;
   logic             done;
   logic             at_last;

   // Input register: the pad bit is held whenever capture is disabled
   always_ff @(posedge eclk or posedge rst) begin
      if (rst) begin
         din_r <= 1'b0;
         acc_r <= 1'b0;
      end else begin
         if (io.sp)
            din_r <= io.d;
         acc_r <= io.sp;
      end
   end

   assign sh_nx = MSB_FIRST ? {sh[WIDTH-2:0], din_r}
                            : {din_r, sh[WIDTH-1:1]};

   assign at_last = acc_r && (cnt == LAST);

   always_ff @(posedge eclk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nx;
   end

   // A discard cycle never shifts or counts, so it can never complete a word
   always_comb begin
      state_nx = state;
      take     = acc_r;
      drop     = 1'b0;
      unique case (state)
         RUN: begin
            if (io.bslip)
               state_nx = SLIP;
         end
         SLIP: begin
            if (acc_r) begin
               take     = 1'b0;
               drop     = 1'b1;
               state_nx = GUARD;
            end
         end
         GUARD: begin
            if (at_last)
               state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
      done = take && (cnt == LAST);
   end

   always_ff @(posedge eclk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         sh       <= '0;
         q_r      <= INIT;
         qvalid_r <= 1'b0;
         ack_r    <= 1'b0;
      end else begin
         qvalid_r <= done;
         ack_r    <= drop;
         if (take) begin
            sh  <= sh_nx;
            cnt <= done ? '0 : cnt + 1'b1;
         end
         if (done)
            q_r <= sh_nx;
      end
   end

   assign io.q        = q_r;
   assign io.qvalid   = qvalid_r;
   assign io.slip_ack = ack_r;

endmodule

// File: tb/tb_ife_deser_bitslip.sv
// Directed bench for ife_deser_bitslip: MSB-first and LSB-first
// instances share one stimulus stream.
module tb_ife_deser_bitslip;

   logic eclk = 1'b0;
   logic rst;
   logic d;
   logic sp;
   logic bslip;

   int nchk = 0;
   int nerr = 0;
   int ecnt = 0;

   int         re_m[$];
   logic [3:0] rw_m[$];
   int         re_l[$];
   logic [3:0] rw_l[$];
   int         ra_m[$];
   int         ra_l[$];

   int         xe[$];
   logic [3:0] xwm[$];
   logic [3:0] xwl[$];
   int         xa[$];

   ife_deser_bitslip_if #(.WIDTH(4)) bm ();
   ife_deser_bitslip_if #(.WIDTH(4)) bl ();

   assign bm.d     = d;
   assign bm.sp    = sp;
   assign bm.bslip = bslip;
   assign bl.d     = d;
   assign bl.sp    = sp;
   assign bl.bslip = bslip;

   ife_deser_bitslip #(
      .WIDTH(4), .MSB_FIRST(1'b1), .INIT(4'hA)
   ) u_msb (
      .eclk(eclk), .rst(rst), .io(bm)
   );

   ife_deser_bitslip #(
      .WIDTH(4), .MSB_FIRST(1'b0), .INIT(4'h0)
   ) u_lsb (
      .eclk(eclk), .rst(rst), .io(bl)
   );

   always #5 eclk = ~eclk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got %0d errors of %0d checks", nerr, nchk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      re_m.delete(); rw_m.delete();
      re_l.delete(); rw_l.delete();
      ra_m.delete(); ra_l.delete();
      xe.delete(); xwm.delete(); xwl.delete(); xa.delete();
      ecnt = 0;
   endtask

   task automatic step(input logic dv, input logic spv, input logic bv);
      d = dv;
      sp = spv;
      bslip = bv;
      @(posedge eclk);
      ecnt++;
      #1;
      if (bm.qvalid) begin
         re_m.push_back(ecnt);
         rw_m.push_back(bm.q);
      end
      if (bl.qvalid) begin
         re_l.push_back(ecnt);
         rw_l.push_back(bl.q);
      end
      if (bm.slip_ack) ra_m.push_back(ecnt);
      if (bl.slip_ack) ra_l.push_back(ecnt);
   endtask

   task automatic xw(input int e, input logic [3:0] wm, input logic [3:0] wl);
      xe.push_back(e);
      xwm.push_back(wm);
      xwl.push_back(wl);
   endtask

   task automatic cmp(input string tag);
      int n;
      chk({tag, "_nw_msb"}, re_m.size(), xe.size());
      chk({tag, "_nw_lsb"}, re_l.size(), xe.size());
      n = (re_m.size() < xe.size()) ? re_m.size() : xe.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_edge_msb%0d", tag, i), re_m[i], xe[i]);
         chk($sformatf("%s_q_msb%0d", tag, i), rw_m[i], xwm[i]);
      end
      n = (re_l.size() < xe.size()) ? re_l.size() : xe.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_edge_lsb%0d", tag, i), re_l[i], xe[i]);
         chk($sformatf("%s_q_lsb%0d", tag, i), rw_l[i], xwl[i]);
      end
      chk({tag, "_nack_msb"}, ra_m.size(), xa.size());
      chk({tag, "_nack_lsb"}, ra_l.size(), xa.size());
      n = (ra_m.size() < xa.size()) ? ra_m.size() : xa.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_ack_msb%0d", tag, i), ra_m[i], xa[i]);
      n = (ra_l.size() < xa.size()) ? ra_l.size() : xa.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_ack_lsb%0d", tag, i), ra_l[i], xa[i]);
   endtask

   initial begin
      logic s[8];
      s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      rst = 1'b1;
      d = 1'b0;
      sp = 1'b0;
      bslip = 1'b0;
      #1;
      chk("init_q_msb", bm.q, 4'hA);
      chk("init_q_lsb", bl.q, 4'h0);
      chk("init_qv", {bm.qvalid, bl.qvalid}, 2'b00);
      chk("init_ack", {bm.slip_ack, bl.slip_ack}, 2'b00);
      repeat (2) @(posedge eclk);
      @(negedge eclk);
      rst = 1'b0;
      clr();

      // basic stream, both bit orders
      for (int i = 0; i < 8; i++) step(s[i], 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      xw(5, 4'b1011, 4'b1101);
      xw(9, 4'b0110, 4'b0110);
      cmp("basic");

      // async reset mid-word
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      sp = 1'b0;
      d = 1'b0;
      #1;
      chk("rst_async_q_msb", bm.q, 4'hA);
      chk("rst_async_q_lsb", bl.q, 4'h0);
      chk("rst_async_qv", {bm.qvalid, bl.qvalid}, 2'b00);
      @(posedge eclk);
      #1;
      chk("rst_hold_qv", {bm.qvalid, bl.qvalid}, 2'b00);
      @(negedge eclk);
      rst = 1'b0;
      clr();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("rst_idle_nqv", re_m.size() + re_l.size(), 0);
      chk("rst_idle_q", bm.q, 4'hA);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      xw(8, 4'b0101, 4'b1010);
      cmp("rst_discard");

      // SP gap of 3 cycles between 2nd and 3rd bits
      clr();
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("gap_hold_q", bm.q, 4'b0101);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("gap_no_early_q", bm.q, 4'b0101);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      xw(8, 4'b1011, 4'b1101);
      cmp("gap");

      // slip mid-word, ignored slip in GUARD, slip again later
      rst = 1'b1;
      #2;
      rst = 1'b0;
      clr();
      for (int e = 1; e <= 36; e++)
         step(((e - 1) % 4) == 0, 1'b1, (e == 11) || (e == 13) || (e == 28));
      xw(5, 4'b1000, 4'b0001);
      xw(9, 4'b1000, 4'b0001);
      xw(14, 4'b1001, 4'b1001);
      xw(18, 4'b0001, 4'b1000);
      xw(22, 4'b0001, 4'b1000);
      xw(26, 4'b0001, 4'b1000);
      xw(31, 4'b0010, 4'b0100);
      xw(35, 4'b0010, 4'b0100);
      xa.push_back(12);
      xa.push_back(29);
      cmp("slip");

      // slip requested on the word-completion cycle
      rst = 1'b1;
      #2;
      rst = 1'b0;
      clr();
      for (int e = 1; e <= 19; e++)
         step(((e - 1) % 4) == 0, 1'b1, e == 9);
      xw(5, 4'b1000, 4'b0001);
      xw(9, 4'b1000, 4'b0001);
      xw(14, 4'b0001, 4'b1000);
      xw(18, 4'b0001, 4'b1000);
      xa.push_back(10);
      cmp("slip_on_qv");

      // reset while a slip is pending
      step(1'b0, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_slip_ack", {bm.slip_ack, bl.slip_ack}, 2'b00);
      @(posedge eclk);
      @(negedge eclk);
      rst = 1'b0;
      clr();
      for (int e = 1; e <= 8; e++)
         step(((e - 1) % 4) == 0, 1'b1, 1'b0);
      xw(5, 4'b1000, 4'b0001);
      cmp("rst_in_slip");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
